// File: rtl/params_fifo_unpack.sv
// Word-wide FIFO that presents its contents as a first-word-fall-through stream of
// OUT_WIDTH slices, low slice first. It feeds the controller's configuration-parameter port.
module params_fifo_unpack #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 16,
    parameter int DEPTH     = 8
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              clear,
    input  logic [IN_WIDTH-1:0]                               enq_din,
    input  logic                                              enq,
    output logic                                              full_n,
    output logic [OUT_WIDTH-1:0]                              dout,
    input  logic                                              deq,
    output logic                                              empty_n,
    output logic [$clog2(DEPTH*(IN_WIDTH/OUT_WIDTH)+1)-1:0]   count
);

    localparam int RATIO  = IN_WIDTH / OUT_WIDTH;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int WCNT_W = $clog2(DEPTH + 1);
    localparam int CNT_W  = $clog2(DEPTH * RATIO + 1);

    typedef logic [RATIO-1:0][OUT_WIDTH-1:0] word_t;

    word_t             mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LANE_W-1:0] lane;
    logic [WCNT_W-1:0] word_cnt;

    logic enq_ok, deq_ok, word_done;

    assign full_n    = (word_cnt != WCNT_W'(DEPTH));
    assign empty_n   = (word_cnt != '0);
    assign count     = CNT_W'(word_cnt) * CNT_W'(RATIO) - CNT_W'(lane);
    assign dout      = mem[rd_ptr][lane];

    // Handshakes are qualified by registered flags only, so a pop that frees
    // the last slot cannot admit a write in the same cycle.
    assign enq_ok    = enq && full_n && !clear;
    assign deq_ok    = deq && empty_n && !clear;
    assign word_done = deq_ok && (lane == LANE_W'(RATIO - 1));

    always_ff @(posedge clk) begin
        if (rst_n && enq_ok)
            mem[wr_ptr] <= enq_din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            lane     <= '0;
            word_cnt <= '0;
        end else begin
            if (enq_ok)
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;

            if (word_done) begin
                lane   <= '0;
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end else if (deq_ok) begin
                lane   <= lane + 1'b1;
            end

            case ({enq_ok, word_done})
                2'b10:   word_cnt <= word_cnt + 1'b1;
                2'b01:   word_cnt <= word_cnt - 1'b1;
                default: word_cnt <= word_cnt;
            endcase
        end
    end

endmodule

// File: doc/params_fifo_unpack.md
Name: params_fifo_unpack

Overview:
- Upstream feeder for the accelerator controller's configuration-parameter port.
- Buffers host-written configuration words of IN_WIDTH bits and presents them as a first-word-fall-through stream of OUT_WIDTH-bit entries, low slice first.
- The stream uses the controller's dout / deq / empty_n handshake.
- Lets the host push packed parameters (two 16-bit config entries per 32-bit write) while the controller consumes one entry per cycle in IDLE.

Parameters:
- IN_WIDTH, 32, width of each host write word; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 16, width of each entry presented to the consumer (controller INPUT_FIFO_WIDTH).
- DEPTH, 8, number of IN_WIDTH words stored; any value ≥2, need not be a power of two.
- RATIO, IN_WIDTH/OUT_WIDTH (derived, localparam), number of output entries per input word.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- clear  input  1  synchronous flush; discards all buffered data.
- enq_din  input  IN_WIDTH  host write data.
- enq  input  1  host write strobe.
- full_n  output  1  high when a word can be accepted this cycle.
- dout  output  OUT_WIDTH  current head entry (valid when empty_n=1).
- deq  input  1  consumer pop strobe.
- empty_n  output  1  high when dout holds a valid entry.
- count  output  $clog2(DEPTH*RATIO+1)  number of OUT_WIDTH entries currently available.

Behaviour:
- Reset (rst_n=0 at clock edge): wr_ptr=0, rd_ptr=0, lane=0, word_cnt=0.
  - Outputs after reset: empty_n=0, full_n=1, count=0.
  - dout is don't-care; storage array is not reset.
- Output decode, all combinational from registered state:
  - full_n = (word_cnt != DEPTH).
  - empty_n = (word_cnt != 0).
  - count = word_cnt*RATIO - lane.
  - dout = mem[rd_ptr][lane*OUT_WIDTH +: OUT_WIDTH].
- Enqueue: accepted iff enq && full_n. Writes mem[wr_ptr] and advances wr_ptr; wraps from DEPTH-1 to 0. enq while full_n=0 is silently dropped, no state change.
- Dequeue: accepted iff deq && empty_n.
  - lane < RATIO-1: lane increments.
  - lane == RATIO-1: lane returns to 0, rd_ptr advances (wrap DEPTH-1→0), word_cnt decrements.
  - deq while empty_n=0 is ignored.
- Latency: a word written into an empty buffer is visible on dout, with empty_n=1, the cycle after the enq edge. There is no same-cycle bypass.
- Simultaneous enq and word-completing deq: word_cnt unchanged. Both pointers advance.
- Simultaneous enq and non-completing deq: word_cnt+1, lane+1.
- Enq on a full buffer is gated by the registered full_n, even if a word-completing deq happens in the same cycle. The host retries next cycle.
- clear=1: same effect as reset on pointers, lane and word_cnt. Takes priority over enq and deq in the same cycle; that enq is discarded.
- rst_n takes priority over clear.
- Reset or clear mid-word (lane≠0) discards the remaining slices of the head word.
- Ordering: entries leave in write order; within a word, bits [OUT_WIDTH-1:0] leave first, most-significant slice last.
- With the controller, deq is driven as empty_n && IDLE. The unit must tolerate deq held high continuously and sustain one entry per cycle while data is present.

Test Plan:
- Reset then write 0xBBBB_AAAA: next cycle empty_n=1, dout=0xAAAA, count=2. deq → dout=0xBBBB, count=1. deq → empty_n=0, count=0, full_n=1.
- Write 8 words 0x0001_0000 … 0x000F_000E back-to-back (DEPTH=8):
  - full_n=0 after the 8th edge, count=16.
  - A 9th enq of 0xDEAD_BEEF is dropped.
  - Draining 16 entries yields 0x0000..0x000F in order, never 0xBEEF.
- Full buffer, lane=1, drive deq and enq=0x1234_5678 together: enq dropped (full_n was 0), word_cnt becomes 7, full_n=1 next cycle. Enq on the following cycle is accepted.
- Continuous deq=1 while the host writes one word every other cycle for 20 words: output stream is uninterrupted and in order. Pointer wrap past DEPTH-1 occurs with no lost or duplicated entry.
- With 3 words buffered and lane=1, assert clear together with enq=0xCAFE_F00D: next cycle empty_n=0, count=0, full_n=1. Subsequent write 0x2222_1111 reads out 0x1111 then 0x2222.
- Feed 12 entries (6 words) into the controller: the controller reaches INITIAL_FILL with config_r[0..11] equal to the 12 low-first slices. Afterwards empty_n=0 and no further deq is accepted.
